// File: rtl/inst_fetch_if.sv
// inst_fetch_if: bundles the instruction-memory, redirect and decode-side
// handshake signals of the fetch stage. The misalign flag exists only when
// FETCH_ALIGN_CHECK_EN is defined.
interface inst_fetch_if;
  // instruction memory request/response
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  // redirect from execute
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  // decode-side valid/ready
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        misalign;
`endif

  // fetch stage side
  modport master (
`ifdef FETCH_ALIGN_CHECK_EN
    output misalign,
`endif
    output imem_req, imem_addr, out_valid, out_inst, out_pc,
    input  imem_ack, imem_rdata, redirect_valid, redirect_pc, out_ready
  );

  // memory / execute / decode side
  modport slave (
`ifdef FETCH_ALIGN_CHECK_EN
    input  misalign,
`endif
    input  imem_req, imem_addr, out_valid, out_inst, out_pc,
    output imem_ack, imem_rdata, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/inst_fetch.sv
// inst_fetch: RISC-V instruction fetch stage. Owns the PC, issues one word
// read at a time to instruction memory, buffers returned {pc, inst} pairs in
// a DEPTH-entry FIFO and hands them to decode over valid/ready. A redirect
// flushes the buffer and restarts fetch at the target; a request already in
// flight is drained and its data thrown away (DROP state).
// Optional feature macro: FETCH_ALIGN_CHECK_EN -- a misaligned redirect target
// sets a sticky misalign flag and parks fetch in HALT until reset. Without it
// the two low target bits are simply cleared.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic         clk,
  input  logic         reset,
  inst_fetch_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    HALT = 2'd3
`endif
  } state_t;

  state_t        state_q;
  logic [31:0]   addr_q;
  logic [31:0]   next_pc_q;
  logic          imem_req_q;
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];
`ifdef FETCH_ALIGN_CHECK_EN
  logic          misalign_q;
  logic          bad_tgt;
  logic          go_halt;
`endif

  logic [31:0]   redir_tgt;
  logic          redirect_take;
  logic          ack_take;
  logic          push;
  logic          pop;
  logic          out_valid_w;
  logic [CW-1:0] count_d;
  logic          has_room;
  logic [DEPTH-1:0] wr_en;

`ifdef FETCH_ALIGN_CHECK_EN
  // Target is taken as-is; a nonzero low pair is an error that halts fetch.
  assign redir_tgt     = bus.redirect_pc;
  assign bad_tgt       = |bus.redirect_pc[1:0];
  // Once the flag is set, any drained request leads to HALT, never a refetch.
  assign go_halt       = bad_tgt | misalign_q;
  assign redirect_take = bus.redirect_valid && (state_q != HALT);
  assign out_valid_w   = (count_q != '0) && !redirect_take && (state_q != HALT);
  assign bus.misalign  = misalign_q;
`else
  // Without the check the target is silently word-aligned.
  assign redir_tgt     = bus.redirect_pc & 32'hFFFF_FFFC;
  assign redirect_take = bus.redirect_valid;
  assign out_valid_w   = (count_q != '0) && !redirect_take;
`endif

  // Acks only count while a request is actually outstanding.
  assign ack_take = imem_req_q && bus.imem_ack;
  // Data returned in DROP or alongside a redirect is never buffered.
  assign push     = (state_q == REQ) && ack_take && !redirect_take;
  assign pop      = out_valid_w && bus.out_ready;
  assign count_d  = count_q + CW'(push) - CW'(pop);
  assign has_room = count_d < CW'(DEPTH);

  assign bus.imem_req  = imem_req_q;
  assign bus.imem_addr = addr_q;
  assign bus.out_valid = out_valid_w;
  assign bus.out_pc    = pc_mem[rd_ptr_q];
  assign bus.out_inst  = inst_mem[rd_ptr_q];

  // One-hot write enable selecting the buffer slot under the write pointer.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
    assign wr_en[gi] = push && (wr_ptr_q == PW'(gi));
  end

  // Buffer storage; entries cleared on reset so the head reads zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) begin
          pc_mem[i]   <= addr_q;
          inst_mem[i] <= bus.imem_rdata;
        end
      end
    end
  end

  // Buffer pointers and occupancy; a redirect empties the buffer outright.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (redirect_take) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  // Fetch FSM: PC tracking, request address and the registered request strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= RESET_PC;
      next_pc_q  <= RESET_PC;
      imem_req_q <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else if (redirect_take) begin
      next_pc_q <= redir_tgt;
`ifdef FETCH_ALIGN_CHECK_EN
      if (bad_tgt) misalign_q <= 1'b1;
`endif
      case (state_q)
        IDLE: begin
`ifdef FETCH_ALIGN_CHECK_EN
          if (go_halt) begin
            state_q    <= HALT;
            imem_req_q <= 1'b0;
          end else
`endif
          begin
            addr_q     <= redir_tgt;
            state_q    <= REQ;
            imem_req_q <= 1'b1;
          end
        end
        REQ: begin
          if (ack_take) begin
            // The request just completed, so the target can go out next cycle.
`ifdef FETCH_ALIGN_CHECK_EN
            if (go_halt) begin
              state_q    <= HALT;
              imem_req_q <= 1'b0;
            end else
`endif
            begin
              addr_q <= redir_tgt;
            end
          end else begin
            // Address must stay put until the in-flight request is acked.
            state_q <= DROP;
          end
        end
        DROP: begin
          if (ack_take) begin
`ifdef FETCH_ALIGN_CHECK_EN
            if (go_halt) begin
              state_q    <= HALT;
              imem_req_q <= 1'b0;
            end else
`endif
            begin
              addr_q  <= redir_tgt;
              state_q <= REQ;
            end
          end
        end
        default: ;
      endcase
    end else begin
      case (state_q)
        IDLE: begin
          if (has_room) begin
            addr_q     <= next_pc_q;
            state_q    <= REQ;
            imem_req_q <= 1'b1;
          end
        end
        REQ: begin
          if (ack_take) begin
            next_pc_q <= addr_q + 32'd4;
            if (has_room) begin
              addr_q <= addr_q + 32'd4;
            end else begin
              state_q    <= IDLE;
              imem_req_q <= 1'b0;
            end
          end
        end
        DROP: begin
          if (ack_take) begin
`ifdef FETCH_ALIGN_CHECK_EN
            if (misalign_q) begin
              state_q    <= HALT;
              imem_req_q <= 1'b0;
            end else
`endif
            begin
              addr_q  <= next_pc_q;
              state_q <= REQ;
            end
          end
        end
`ifdef FETCH_ALIGN_CHECK_EN
        HALT: ;
`endif
        default: begin
          state_q    <= IDLE;
          imem_req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed bench for inst_fetch (DEPTH=2, RESET_PC=0).
// A behavioural memory answers requests with a programmable wait count.
module tb_inst_fetch;

  logic clk = 1'b0;
  logic reset = 1'b1;

  inst_fetch_if bus ();

  inst_fetch #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   lat       = 0;
  logic stray_ack = 1'b0;
  int   ack_cnt   = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0013;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else pass_cnt++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Handshakes completed, seen at the sampling edge.
  always @(posedge clk) begin
    if (bus.imem_req && bus.imem_ack) ack_cnt <= ack_cnt + 1;
  end

  // Memory responder: ack after lat waiting cycles, driven on the falling edge.
  initial begin
    int wcnt;
    wcnt = 0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (reset || !bus.imem_req) begin
        bus.imem_ack   = stray_ack;
        bus.imem_rdata = 32'hBAD0_BAD0;
        wcnt = 0;
      end else if (wcnt >= lat) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = mem_word(bus.imem_addr);
        wcnt = 0;
      end else begin
        bus.imem_ack = 1'b0;
        wcnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.out_ready      = 1'b1;

    // Reset values
    step();
    check_eq("rst_req", {31'd0, bus.imem_req}, 32'd0);
    check_eq("rst_addr", bus.imem_addr, 32'h0);
    check_eq("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check_eq("rst_inst", bus.out_inst, 32'h0);
    check_eq("rst_pc", bus.out_pc, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
    check_eq("rst_misalign", {31'd0, bus.misalign}, 32'd0);
`endif

    // Zero-wait streaming
    lat = 0;
    reset = 1'b0;
    check_eq("s_req_pre", {31'd0, bus.imem_req}, 32'd0);
    step();
    check_eq("s_req0", {31'd0, bus.imem_req}, 32'd1);
    check_eq("s_addr0", bus.imem_addr, 32'h0);
    step();
    check_eq("s_addr4", bus.imem_addr, 32'h4);
    check_eq("s_valid0", {31'd0, bus.out_valid}, 32'd1);
    check_eq("s_pc0", bus.out_pc, 32'h0);
    check_eq("s_inst0", bus.out_inst, mem_word(32'h0));
    step();
    check_eq("s_addr8", bus.imem_addr, 32'h8);
    check_eq("s_pc4", bus.out_pc, 32'h4);
    check_eq("s_inst4", bus.out_inst, mem_word(32'h4));
    step();
    check_eq("s_addrc", bus.imem_addr, 32'hC);
    check_eq("s_pc8", bus.out_pc, 32'h8);

    // Backpressure: buffer fills after two acks, then fetch parks
    bus.out_ready = 1'b0;
    do_reset();
    base = ack_cnt;
    repeat (5) step();
    check_eq("bp_acks", 32'(ack_cnt - base), 32'd2);
    check_eq("bp_req_idle", {31'd0, bus.imem_req}, 32'd0);
    check_eq("bp_head", bus.out_pc, 32'h0);
    check_eq("bp_valid", {31'd0, bus.out_valid}, 32'd1);
    bus.out_ready = 1'b1;
    #1;
    check_eq("bp_req_popcyc", {31'd0, bus.imem_req}, 32'd0);
    step();
    check_eq("bp_req_after", {31'd0, bus.imem_req}, 32'd1);
    check_eq("bp_addr8", bus.imem_addr, 32'h8);
    check_eq("bp_head4", bus.out_pc, 32'h4);

    // 3-cycle memory, redirect while the PC 4 request is in flight
    lat = 3;
    do_reset();
    repeat (5) step();
    check_eq("l3_addr4", bus.imem_addr, 32'h4);
    check_eq("l3_pc0", bus.out_pc, 32'h0);
    check_eq("l3_valid0", {31'd0, bus.out_valid}, 32'd1);
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    #1;
    check_eq("l3_hold_a", bus.imem_addr, 32'h4);
    check_eq("l3_novalid_a", {31'd0, bus.out_valid}, 32'd0);
    step();
    bus.redirect_valid = 1'b0;
    check_eq("l3_hold_b", bus.imem_addr, 32'h4);
    check_eq("l3_req_b", {31'd0, bus.imem_req}, 32'd1);
    step();
    check_eq("l3_hold_c", bus.imem_addr, 32'h4);
    step();
    check_eq("l3_addr100", bus.imem_addr, 32'h100);
    check_eq("l3_drop", {31'd0, bus.out_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("l3_wait", {31'd0, bus.out_valid}, 32'd0);
    end
    step();
    check_eq("l3_valid100", {31'd0, bus.out_valid}, 32'd1);
    check_eq("l3_pc100", bus.out_pc, 32'h100);
    check_eq("l3_inst100", bus.out_inst, mem_word(32'h100));

    // Redirect coincident with the ack of PC 8
    lat = 0;
    do_reset();
    repeat (3) step();
    check_eq("co_pc4", bus.out_pc, 32'h4);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    #1;
    check_eq("co_forced0", {31'd0, bus.out_valid}, 32'd0);
    step();
    bus.redirect_valid = 1'b0;
    check_eq("co_addr100", bus.imem_addr, 32'h100);
    check_eq("co_flushed", {31'd0, bus.out_valid}, 32'd0);
    step();
    check_eq("co_valid", {31'd0, bus.out_valid}, 32'd1);
    check_eq("co_pc100", bus.out_pc, 32'h100);

    // Reset in the middle of a request; stray ack during reset ignored
    bus.out_ready = 1'b0;
    do_reset();
    repeat (2) step();
    check_eq("mr_req_pre", {31'd0, bus.imem_req}, 32'd1);
    reset = 1'b1;
    stray_ack = 1'b1;
    #1;
    check_eq("mr_req0", {31'd0, bus.imem_req}, 32'd0);
    check_eq("mr_valid0", {31'd0, bus.out_valid}, 32'd0);
    check_eq("mr_addr0", bus.imem_addr, 32'h0);
    check_eq("mr_inst0", bus.out_inst, 32'h0);
    repeat (2) step();
    reset = 1'b0;
    stray_ack = 1'b0;
    step();
    check_eq("mr_restart_req", {31'd0, bus.imem_req}, 32'd1);
    check_eq("mr_restart_addr", bus.imem_addr, 32'h0);
    check_eq("mr_empty", {31'd0, bus.out_valid}, 32'd0);
    step();
    check_eq("mr_valid", {31'd0, bus.out_valid}, 32'd1);
    check_eq("mr_inst", bus.out_inst, mem_word(32'h0));

    // Misaligned redirect target
    bus.out_ready = 1'b1;
    do_reset();
    repeat (2) step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h102;
    step();
    bus.redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    check_eq("ma_flag", {31'd0, bus.misalign}, 32'd1);
    check_eq("ma_req", {31'd0, bus.imem_req}, 32'd0);
    check_eq("ma_valid", {31'd0, bus.out_valid}, 32'd0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h200;
    step();
    bus.redirect_valid = 1'b0;
    step();
    check_eq("ma_hold_req", {31'd0, bus.imem_req}, 32'd0);
    check_eq("ma_hold_flag", {31'd0, bus.misalign}, 32'd1);
    reset = 1'b1;
    #1;
    check_eq("ma_clear", {31'd0, bus.misalign}, 32'd0);
`else
    check_eq("ma_addr100", bus.imem_addr, 32'h100);
    check_eq("ma_req", {31'd0, bus.imem_req}, 32'd1);
    step();
    check_eq("ma_pc100", bus.out_pc, 32'h100);
`endif

    // PC wrap past the top of the address space
    do_reset();
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    step();
    bus.redirect_valid = 1'b0;
    check_eq("wr_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
    step();
    check_eq("wr_addr0", bus.imem_addr, 32'h0);
    check_eq("wr_pc_top", bus.out_pc, 32'hFFFF_FFFC);
    step();
    check_eq("wr_pc0", bus.out_pc, 32'h0);
    check_eq("wr_inst0", bus.out_inst, mem_word(32'h0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
